// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I program-counter datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

  // Target select encoding driven by the control unit.
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_src_t;

  // Reason recorded when the PC unit enters its fault state.
  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_ILLEGAL  = 2'b10
  } fault_cause_t;

  // Control state of the PC unit.
  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_FAULT = 1'b1
  } pc_state_t;

  // Every RV32I instruction occupies one 32-bit word.
  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target_gen.sv
// Next-PC target selection with misalignment and illegal-select detection.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the target is taken.
module pc_target_gen
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic [1:0]       i_pc_src,
  input  logic [WIDTH-1:0] i_imm_op,
  input  logic [WIDTH-1:0] i_rs1_val,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic [WIDTH-1:0] o_next_pc,
  output logic             o_misalign,
  output logic             o_illegal
);

  logic [WIDTH-1:0] w_jalr_sum;

  assign o_pc_plus4 = i_pc + WIDTH'(INSTR_BYTES);
  assign w_jalr_sum = i_rs1_val + i_imm_op;

  // Select the candidate target; all sums wrap modulo 2^WIDTH.
  always_comb begin
    o_next_pc = i_pc;
    o_illegal = 1'b0;
    case (i_pc_src)
      PC_PLUS4:  o_next_pc = o_pc_plus4;
      PC_BRANCH: o_next_pc = i_pc + i_imm_op;
      PC_JALR:   o_next_pc = {w_jalr_sum[WIDTH-1:1], 1'b0};
      default: begin
        // Reserved select: hold the current PC and flag it.
        o_next_pc = i_pc;
        o_illegal = 1'b1;
      end
    endcase
  end

  // A word-misaligned target cannot be fetched.
  assign o_misalign = (o_next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with stall, fault capture and retired-instruction counter.
// Latency: one edge from target select to pc; pc_plus4/next_pc are combinational.
// Backpressure: en=0 stalls and holds all state; FAULT holds until fault_clr.
module pc_unit
  import core_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] imm_op,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic             fault_clr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] next_pc,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [WIDTH-1:0] fault_pc,
  output logic [CNT_W-1:0] retired_cnt
);

  pc_state_t        r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_fault;
  fault_cause_t     r_cause;
  logic [WIDTH-1:0] r_fault_pc;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_pc_plus4;
  logic             w_misalign;
  logic             w_illegal;

  pc_target_gen #(
    .WIDTH (WIDTH)
  ) u_target_gen (
    .i_pc       (r_pc),
    .i_pc_src   (pc_src),
    .i_imm_op   (imm_op),
    .i_rs1_val  (rs1_val),
    .o_pc_plus4 (w_pc_plus4),
    .o_next_pc  (w_next_pc),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  // RUN/FAULT control: advance, capture a fault, or wait for fault_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PC_RUN;
      r_pc       <= RESET_VECTOR;
      r_fault    <= 1'b0;
      r_cause    <= FC_NONE;
      r_fault_pc <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        PC_RUN: begin
          if (en) begin
            if (w_illegal || w_misalign) begin
              // The faulting instruction's PC is kept; no advance is counted.
              r_state    <= PC_FAULT;
              r_fault    <= 1'b1;
              r_cause    <= w_illegal ? FC_ILLEGAL : FC_MISALIGN;
              r_fault_pc <= r_pc;
            end else begin
              r_pc  <= w_next_pc;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        PC_FAULT: begin
          // fault_pc and the counter survive a clear for post-mortem reads.
          if (fault_clr) begin
            r_state <= PC_RUN;
            r_pc    <= RESET_VECTOR;
            r_fault <= 1'b0;
            r_cause <= FC_NONE;
          end
        end
        default: r_state <= PC_RUN;
      endcase
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign next_pc     = w_next_pc;
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign fault_pc    = r_fault_pc;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table plus hand-written corner sequences.
// Latency: expected post-edge state queued at drive time, popped #1 after the edge.
// Backpressure: exercised through en=0 stalls and the FAULT hold state.
module tb_pc_unit;

  localparam int unsigned CNT_W = 4;

  typedef struct {
    bit        rst;
    bit        en;
    bit        clr;
    bit [1:0]  src;
    bit [31:0] imm;
    bit [31:0] rs1;
    bit        chk_npc;
    bit [31:0] npc;
    bit [31:0] pc;
    bit        flt;
    bit [1:0]  cause;
    bit [31:0] fpc;
    bit [3:0]  cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       pc_src = 2'b00;
  logic [31:0]      imm_op = '0;
  logic [31:0]      rs1_val = '0;
  logic             fault_clr = 1'b0;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      next_pc;
  logic             fault;
  logic [1:0]       fault_cause;
  logic [31:0]      fault_pc;
  logic [CNT_W-1:0] retired_cnt;

  int errors = 0;
  int checks = 0;

  vec_t tbl[$];
  vec_t sb[$];

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pc_src      (pc_src),
    .imm_op      (imm_op),
    .rs1_val     (rs1_val),
    .fault_clr   (fault_clr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_pc    (fault_pc),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit e, bit c, bit [1:0] s, bit [31:0] im, bit [31:0] rv,
                              bit cn, bit [31:0] np, bit [31:0] p, bit f, bit [1:0] fc,
                              bit [31:0] fp, bit [3:0] ct);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.src = s; v.imm = im; v.rs1 = rv;
    v.chk_npc = cn; v.npc = np; v.pc = p; v.flt = f; v.cause = fc; v.fpc = fp; v.cnt = ct;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check combinational target, then the post-edge state.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; fault_clr = v.clr; pc_src = v.src; imm_op = v.imm; rs1_val = v.rs1;
    sb.push_back(v);
    #1;
    if (v.chk_npc) chk($sformatf("next_pc[%0d]", idx), next_pc, v.npc);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("pc[%0d]", idx), pc, e.pc);
    chk($sformatf("pc_plus4[%0d]", idx), pc_plus4, e.pc + 32'd4);
    chk($sformatf("fault[%0d]", idx), {31'd0, fault}, {31'd0, e.flt});
    chk($sformatf("fault_cause[%0d]", idx), {30'd0, fault_cause}, {30'd0, e.cause});
    chk($sformatf("fault_pc[%0d]", idx), fault_pc, e.fpc);
    chk($sformatf("retired_cnt[%0d]", idx), {28'd0, retired_cnt}, {28'd0, e.cnt});
  endtask

  initial begin
    //            rst en clr src    imm           rs1           chk npc           pc            f fc    fpc           cnt
    tbl.push_back(mk(1, 0, 0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 2'b00, 32'h0,     4'd0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 32'h0,        32'h0,        1, 32'h4,        32'h4,        0, 2'b00, 32'h0,     4'd1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 32'h0,        32'h0,        1, 32'h8,        32'h8,        0, 2'b00, 32'h0,     4'd2));
    tbl.push_back(mk(0, 1, 0, 2'b00, 32'h0,        32'h0,        1, 32'hC,        32'hC,        0, 2'b00, 32'h0,     4'd3));
    tbl.push_back(mk(0, 1, 0, 2'b01, 32'hF4,       32'h0,        1, 32'h100,      32'h100,      0, 2'b00, 32'h0,     4'd4));
    tbl.push_back(mk(0, 1, 0, 2'b01, 32'hFFFF_FFF0, 32'h0,       1, 32'hF0,       32'hF0,       0, 2'b00, 32'h0,     4'd5));
    // Stalls: held state; a misaligned JALR and a stray fault_clr while stalled are ignored.
    tbl.push_back(mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'hF4,       32'hF0,       0, 2'b00, 32'h0,     4'd5));
    tbl.push_back(mk(0, 0, 1, 2'b10, 32'h0,        32'h2,        1, 32'h2,        32'hF0,       0, 2'b00, 32'h0,     4'd5));
    tbl.push_back(mk(0, 1, 0, 2'b10, 32'h3,        32'h2001,     1, 32'h2004,     32'h2004,     0, 2'b00, 32'h0,     4'd6));
    tbl.push_back(mk(0, 1, 0, 2'b10, 32'h1,        32'h2001,     1, 32'h2002,     32'h2004,     1, 2'b01, 32'h2004,  4'd6));
    // FAULT: everything frozen whatever en/pc_src do.
    tbl.push_back(mk(0, 1, 0, 2'b00, 32'h0,        32'h0,        1, 32'h2008,     32'h2004,     1, 2'b01, 32'h2004,  4'd6));
    tbl.push_back(mk(0, 0, 0, 2'b01, 32'h10,       32'h0,        1, 32'h2014,     32'h2004,     1, 2'b01, 32'h2004,  4'd6));
    tbl.push_back(mk(0, 1, 0, 2'b11, 32'h0,        32'h0,        1, 32'h2004,     32'h2004,     1, 2'b01, 32'h2004,  4'd6));
    tbl.push_back(mk(0, 1, 0, 2'b10, 32'h0,        32'h3,        1, 32'h2,        32'h2004,     1, 2'b01, 32'h2004,  4'd6));
    tbl.push_back(mk(0, 0, 1, 2'b00, 32'h0,        32'h0,        1, 32'h2008,     32'h0,        0, 2'b00, 32'h2004,  4'd6));
    // Wrap of pc and of the 4-bit retired counter.
    tbl.push_back(mk(0, 1, 0, 2'b01, 32'hFFFF_FFFC, 32'h0,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 2'b00, 32'h2004, 4'd7));
    tbl.push_back(mk(0, 1, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0,        32'h0,        0, 2'b00, 32'h2004,  4'd8));
    for (int k = 1; k <= 7; k++) begin
      tbl.push_back(mk(0, 1, 0, 2'b00, 32'h0, 32'h0, 1, 32'(4 * k), 32'(4 * k), 0, 2'b00, 32'h2004, 4'(8 + k)));
    end
    tbl.push_back(mk(0, 1, 0, 2'b00, 32'h0,        32'h0,        1, 32'h20,       32'h20,       0, 2'b00, 32'h2004,  4'd0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 32'h0,        32'h0,        1, 32'h24,       32'h24,       0, 2'b00, 32'h2004,  4'd1));
    // Reserved select faults; then rst together with fault_clr fully resets.
    tbl.push_back(mk(0, 1, 0, 2'b11, 32'h0,        32'h0,        1, 32'h24,       32'h24,       1, 2'b10, 32'h24,    4'd1));
    tbl.push_back(mk(1, 1, 1, 2'b00, 32'h0,        32'h0,        1, 32'h28,       32'h0,        0, 2'b00, 32'h0,     4'd0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Reset mid-stall, then reset dominating an illegal select with en=1.
    run_vec(mk(0, 1, 0, 2'b00, 32'h0, 32'h0,  1, 32'h4,  32'h4, 0, 2'b00, 32'h0, 4'd1), 100);
    run_vec(mk(0, 1, 0, 2'b00, 32'h0, 32'h0,  1, 32'h8,  32'h8, 0, 2'b00, 32'h0, 4'd2), 101);
    run_vec(mk(0, 0, 0, 2'b10, 32'h0, 32'h11, 1, 32'h10, 32'h8, 0, 2'b00, 32'h0, 4'd2), 102);
    run_vec(mk(1, 0, 0, 2'b00, 32'h0, 32'h0,  1, 32'hC,  32'h0, 0, 2'b00, 32'h0, 4'd0), 103);
    run_vec(mk(1, 1, 0, 2'b11, 32'h0, 32'h0,  1, 32'h0,  32'h0, 0, 2'b00, 32'h0, 4'd0), 104);

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
